// File: rtl/not16_bist_if.sv
// Bus between the not16_bist engine (slave) and its controller/DUT harness (master).
// Optional inject line exists only when NOT16_BIST_FAULT_INJECT_EN is defined.
interface not16_bist_if;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = 9;

  logic          start;
`ifdef NOT16_BIST_FAULT_INJECT_EN
  logic          inject;
`endif
  logic [DW-1:0] dut_in;
  logic [DW-1:0] dut_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] fail_count;
  logic [DW-1:0] fail_vec;
  logic [IW-1:0] vec_idx;

`ifdef NOT16_BIST_FAULT_INJECT_EN
  modport master (output start, output inject, output dut_out,
                  input dut_in, input busy, input done, input pass,
                  input fail_count, input fail_vec, input vec_idx);
  modport slave  (input start, input inject, input dut_out,
                  output dut_in, output busy, output done, output pass,
                  output fail_count, output fail_vec, output vec_idx);
`else
  modport master (output start, output dut_out,
                  input dut_in, input busy, input done, input pass,
                  input fail_count, input fail_vec, input vec_idx);
  modport slave  (input start, input dut_out,
                  output dut_in, output busy, output done, output pass,
                  output fail_count, output fail_vec, output vec_idx);
`endif
endinterface

// File: rtl/not16_bist.sv
// BIST engine for 16-bit bitwise-NOT datapaths: directed + LFSR vectors, checked against ~dut_in.
// Define NOT16_BIST_FAULT_INJECT_EN to add the inject input that corrupts the golden value.
module not16_bist #(
  parameter int unsigned NUM_RANDOM = 64,
  parameter int unsigned SETTLE     = 1,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  not16_bist_if.slave  bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = 9;
  localparam int unsigned SW = 4;

  localparam logic [IW-1:0] LAST_IDX    = IW'(4 + NUM_RANDOM);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam logic [DW-1:0] SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dut_in_q, dut_in_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [CW-1:0] fail_count_q, fail_count_d;
  logic [DW-1:0] fail_vec_q, fail_vec_d;
  logic [IW-1:0] vec_idx_q, vec_idx_d;
  logic [DW-1:0] lfsr_q, lfsr_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;

  logic          inject_c;
  logic [DW-1:0] golden_c;
  logic          mismatch_c;
  logic          last_c;

`ifdef NOT16_BIST_FAULT_INJECT_EN
  assign inject_c = bus.inject;
`else
  assign inject_c = 1'b0;
`endif

  // Case inequality so an X/Z response is reported as a failure.
  assign golden_c   = ~dut_in_q ^ {{(DW-1){1'b0}}, inject_c};
  assign mismatch_c = (bus.dut_out !== golden_c);
  assign last_c     = (vec_idx_q == LAST_IDX);

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] l);
    return {l[DW-2:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= '0;
      fail_vec_q   <= '0;
      vec_idx_q    <= '0;
      lfsr_q       <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      fail_vec_q   <= fail_vec_d;
      vec_idx_q    <= vec_idx_d;
      lfsr_q       <= lfsr_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_LOAD;
      S_LOAD:   state_d = S_DRIVE;
      S_DRIVE:  state_d = (SETTLE == 0) ? S_CHECK : S_SETTLE;
      S_SETTLE: if (settle_cnt_q == SETTLE_LAST) state_d = S_CHECK;
      S_CHECK:  state_d = last_c ? S_DONE : S_DRIVE;
      S_DONE:   if (bus.start) state_d = S_LOAD;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dut_in_d     = dut_in_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    fail_vec_d   = fail_vec_q;
    vec_idx_d    = vec_idx_q;
    lfsr_d       = lfsr_q;
    settle_cnt_d = settle_cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          done_d = 1'b0;
          pass_d = 1'b0;
        end
      end
      S_LOAD: begin
        busy_d       = 1'b1;
        fail_count_d = '0;
        fail_vec_d   = '0;
        vec_idx_d    = '0;
        lfsr_d       = SEED_EFF;
      end
      S_DRIVE: begin
        settle_cnt_d = '0;
        unique case (vec_idx_q)
          IW'(0):  dut_in_d = 16'h0000;
          IW'(1):  dut_in_d = 16'hFFFF;
          IW'(2):  dut_in_d = 16'hAAAA;
          IW'(3):  dut_in_d = 16'h3CC3;
          IW'(4):  dut_in_d = 16'h1234;
          default: begin
            dut_in_d = lfsr_q;
            lfsr_d   = lfsr_step(lfsr_q);
          end
        endcase
      end
      S_SETTLE: settle_cnt_d = settle_cnt_q + SW'(1);
      S_CHECK: begin
        if (mismatch_c) begin
          if (fail_count_q == '0)        fail_vec_d   = dut_in_q;
          if (fail_count_q != {CW{1'b1}}) fail_count_d = fail_count_q + CW'(1);
        end
        if (last_c) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (fail_count_d == '0);
        end else begin
          vec_idx_d = vec_idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.dut_in     = dut_in_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_count = fail_count_q;
  assign bus.fail_vec   = fail_vec_q;
  assign bus.vec_idx    = vec_idx_q;
endmodule
